// File: rtl/hs_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : hs_ram_arbiter_if
// Purpose  : Work-RAM sharing bus between CPU, hiscore engine and RAM port.
// Revision : 1.0 - initial release
// ============================================================================
interface hs_ram_arbiter_if #(
  parameter int AW = 16
);
  logic          pause_in;
  logic          cpu_cs;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_dout;
  logic          cpu_we;
  logic          hs_req;
  logic [AW-1:0] hs_addr;
  logic [7:0]    hs_dout;
  logic          hs_we;
  logic          hs_grant;
  logic          cpu_pause;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_din;
  logic          ram_we;
  logic          timeout_flg;

  modport master (
    output pause_in, cpu_cs, cpu_addr, cpu_dout, cpu_we,
    output hs_req, hs_addr, hs_dout, hs_we,
    input  hs_grant, cpu_pause, ram_addr, ram_din, ram_we, timeout_flg
  );

  modport slave (
    input  pause_in, cpu_cs, cpu_addr, cpu_dout, cpu_we,
    input  hs_req, hs_addr, hs_dout, hs_we,
    output hs_grant, cpu_pause, ram_addr, ram_din, ram_we, timeout_flg
  );
endinterface
`default_nettype wire

// File: rtl/hs_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hs_ram_arbiter
// Purpose  : Pauses the CPU, waits for a quiet bus, then lends the work-RAM
//            port to the hiscore engine; hands it back after a short hold-off.
// Revision : 1.0 - initial release
// ============================================================================
module hs_ram_arbiter #(
  parameter int AW      = 16,
  parameter int SETTLE  = 4,
  parameter int HOLD    = 2,
  parameter int TIMEOUT = 255
) (
  input  wire              clk_sys,
  input  wire              reset_n,
  hs_ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic [3:0] c_settle_last  = 4'(SETTLE - 1);
  localparam logic [3:0] c_hold_last    = 4'(HOLD - 1);
  localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_idle_cnt, w_idle_nxt;
  logic [7:0] r_to_cnt, w_to_nxt;
  logic       r_hs_grant, r_arb_pause, r_sel_hs, r_timeout_flg;
  logic       w_tflag_nxt;
  logic [AW-1:0] w_ram_addr;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_idle_cnt    <= 4'd0;
      r_to_cnt      <= 8'd0;
      r_hs_grant    <= 1'b0;
      r_arb_pause   <= 1'b0;
      r_sel_hs      <= 1'b0;
      r_timeout_flg <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_idle_cnt    <= w_idle_nxt;
      r_to_cnt      <= w_to_nxt;
      r_hs_grant    <= (w_state_nxt == ST_GRANT);
      r_arb_pause   <= (w_state_nxt != ST_IDLE);
      r_sel_hs      <= (w_state_nxt == ST_GRANT) || (w_state_nxt == ST_RELEASE);
      r_timeout_flg <= w_tflag_nxt;
    end
  end

  // idle_cnt doubles as the hold-off counter while in RELEASE.
  always_comb begin
    w_state_nxt = r_state;
    w_idle_nxt  = r_idle_cnt;
    w_to_nxt    = r_to_cnt;
    w_tflag_nxt = r_timeout_flg;
    case (r_state)
      ST_IDLE: begin
        if (bus.hs_req) begin
          w_state_nxt = ST_DRAIN;
          w_idle_nxt  = 4'd0;
          w_to_nxt    = 8'd0;
        end
      end
      ST_DRAIN: begin
        if (bus.cpu_cs)
          w_idle_nxt = 4'd0;
        else if (r_idle_cnt != 4'hF)
          w_idle_nxt = r_idle_cnt + 4'd1;
        if (r_to_cnt != 8'hFF)
          w_to_nxt = r_to_cnt + 8'd1;
        if (!bus.hs_req) begin
          w_state_nxt = ST_RELEASE;
          w_idle_nxt  = 4'd0;
        end else if (!bus.cpu_cs && (r_idle_cnt == c_settle_last)) begin
          w_state_nxt = ST_GRANT;
        end else if (r_to_cnt == c_timeout_last) begin
          w_state_nxt = ST_GRANT;
          w_tflag_nxt = 1'b1;
        end
      end
      ST_GRANT: begin
        if (!bus.hs_req) begin
          w_state_nxt = ST_RELEASE;
          w_idle_nxt  = 4'd0;
        end
      end
      ST_RELEASE: begin
        if (r_idle_cnt == c_hold_last)
          w_state_nxt = ST_IDLE;
        else if (r_idle_cnt != 4'hF)
          w_idle_nxt = r_idle_cnt + 4'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_ram_addr      = r_sel_hs ? bus.hs_addr : bus.cpu_addr;
  assign bus.ram_addr    = w_ram_addr;
  assign bus.ram_din     = r_sel_hs ? bus.hs_dout : bus.cpu_dout;
  // hs_grant is low in RELEASE, which masks late hiscore writes.
  assign bus.ram_we      = r_sel_hs ? (bus.hs_we & r_hs_grant) : bus.cpu_we;
  assign bus.hs_grant    = r_hs_grant;
  assign bus.cpu_pause   = r_arb_pause | bus.pause_in;
  assign bus.timeout_flg = r_timeout_flg;

endmodule
`default_nettype wire
